seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked ALU for the datapath.
- Single-cycle logic and arithmetic ops are registered with 1-cycle latency; MUL runs as an iterative shift-add multiplier.
- Zero flag is registered with the result and is defined for every op.
- Sits between the register-file read stage and writeback; the core stalls on `in_ready` and `out_valid`.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, width of the MUL iteration counter (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept an op.
- ALUC  in  4  opcode.
- ALUIN1  in  WIDTH  operand A.
- ALUIN2  in  WIDTH  operand B.
- out_valid  out  1  ALU_OUT/Zero/illegal valid.
- out_ready  in  1  consumer accepts result.
- ALU_OUT  out  WIDTH  result.
- Zero  out  1  1 when ALU_OUT == 0.
- illegal  out  1  opcode not in table.
- Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD (mod 2^WIDTH).
  - 0110 SUB (mod 2^WIDTH).
  - 0111 SLT: signed, result 1 or 0.
  - 0100 SLL: A << B[CNT_W-2:0].
  - 0101 SRL: logical.
  - 1000 CMPEQ: result A−B; Zero=1 iff A==B.
  - 1100 CMPNE: result A−B; Zero=1 iff A!=B.
  - 0011 MUL: low WIDTH bits of A*B, unsigned.
  - Any other code: ALU_OUT=0, Zero=1, illegal=1, single-cycle.
- Zero rule: Zero = (ALU_OUT==0) for all ops except CMPNE, where Zero = (ALU_OUT!=0).
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, operands and opcode are captured.
  - Single-cycle op: result is computed and registered, go to DONE. out_valid rises on the next edge (latency 1).
  - MUL: load the multiplicand, multiplier and zeroed accumulator, set counter=WIDTH, go to MUL.
- MUL:
  - Each cycle: if multiplier[0], accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter−1.
  - When counter reaches 0, go to DONE. Total latency from acceptance to out_valid is WIDTH+1 cycles.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; ALU_OUT, Zero and illegal are held stable.
  - On out_ready, go to IDLE. in_ready returns the following cycle; there is no same-cycle re-accept.
  - If out_ready is held high, it is consumed on the first DONE cycle.
- Result stability: outputs change only on the edge entering DONE.
- Operand stability: ALUIN1/ALUIN2/ALUC may change after acceptance without effect.
- in_valid while not in_ready: ignored; the upstream block must hold it.
- Reset, including mid-MUL: state=IDLE, ALU_OUT=0, Zero=0, illegal=0, out_valid=0, in_ready=1 after release; the in-flight op is discarded.
- Asynchronous assert, synchronous deassertion assumed from the upstream reset synchroniser.
- Full handshake per op, no internal buffering: at most one op in flight.

Optional Feature:
- Macro: SEQ_ALU_OVF_EN.
- When defined:
  - Adds output port `ovf` (1 bit), registered alongside ALU_OUT.
  - ovf=1 on signed overflow for ADD, SUB, CMPEQ and CMPNE.
  - For MUL, ovf=1 if the full 2·WIDTH unsigned product exceeds WIDTH bits; the accumulator is widened to 2·WIDTH.
  - ovf=0 otherwise; reset value 0.
- When undefined: no `ovf` port; the accumulator is WIDTH bits.

Test Plan:
- Reset mid-MUL:
  - Stimulus: rst_n low during the 10th cycle of MUL 7×9.
  - Required: out_valid=0 and ALU_OUT=0 immediately; in_ready=1 after release.
  - Next op ADD 2+3 → 5 with latency 1.
- ADD and SUB wrap (WIDTH=32):
  - ADD 0xFFFF_FFFF+1 → ALU_OUT=0, Zero=1, out_valid one cycle after acceptance.
  - SUB 5−7 → 0xFFFF_FFFE, Zero=0.
- Compare ops:
  - CMPEQ 0x1234,0x1234 → Zero=1.
  - CMPNE 0x1234,0x1234 → Zero=0.
  - CMPNE 3,4 → Zero=1.
- MUL with back-pressure:
  - Stimulus: MUL 0x0001_0003×0x0000_0005 with out_ready=0 for 5 cycles after out_valid.
  - Required: out_valid exactly 33 cycles after acceptance; ALU_OUT=0x0005_000F held stable; in_ready=0 until the cycle after out_ready.
- SLT, shift and illegal ops:
  - SLT 0xFFFF_FFFF,1 → 1.
  - SLL 1,31 → 0x8000_0000.
  - SRL 0x8000_0000,31 → 1.
  - ALUC=1111 → ALU_OUT=0, Zero=1, illegal=1.
- Overflow (SEQ_ALU_OVF_EN defined):
  - ADD 0x7FFF_FFFF+1 → ovf=1.
  - MUL 0x1_0000×0x1_0000 → ALU_OUT=0, ovf=1.
  - ADD 1+1 → ovf=0.

Source files
------------

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result handshake bundle for seq_alu (ovf present when SEQ_ALU_OVF_EN is defined)
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ALUC;
   logic [WIDTH-1:0] ALUIN1;
   logic [WIDTH-1:0] ALUIN2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALU_OUT;
   logic             Zero;
   logic             illegal;
`ifdef SEQ_ALU_OVF_EN
   logic             ovf;
`endif

   // upstream stage / result consumer side
   modport master (
      output in_valid, ALUC, ALUIN1, ALUIN2, out_ready,
`ifdef SEQ_ALU_OVF_EN
      input  ovf,
`endif
      input  in_ready, out_valid, ALU_OUT, Zero, illegal
   );

   // ALU side
   modport slave (
      input  in_valid, ALUC, ALUIN1, ALUIN2, out_ready,
`ifdef SEQ_ALU_OVF_EN
      output ovf,
`endif
      output in_ready, out_valid, ALU_OUT, Zero, illegal
   );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU, 1-cycle logic/arith ops, iterative shift-add MUL; SEQ_ALU_OVF_EN adds ovf
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_alu_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef SEQ_ALU_OVF_EN
   // full product is kept so the upper half can flag MUL overflow
   localparam int ACC_W = 2 * WIDTH;
`else
   localparam int ACC_W = WIDTH;
`endif

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_MUL   = 4'b0011;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_CMPEQ = 4'b1000;
   localparam logic [3:0] OP_CMPNE = 4'b1100;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           state;
   logic             ready_q;
   logic             valid_q;
   logic [WIDTH-1:0] res_q;
   logic             zero_q;
   logic             illegal_q;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [CNT_W-2:0] shamt;
   logic             slt;
   logic [WIDTH-1:0] sc_res;
   logic             sc_zero;
   logic             sc_illegal;
   logic [ACC_W-1:0] next_acc;

   assign a     = bus.ALUIN1;
   assign b     = bus.ALUIN2;
   assign sum   = a + b;
   assign diff  = a - b;
   assign shamt = b[CNT_W-2:0];
   assign slt   = $signed(a) < $signed(b);

   // one shift-add step: accumulate the multiplicand when the multiplier LSB is set
   assign next_acc = acc + (mplier[0] ? mcand : '0);

   // single-cycle result and its flags, evaluated on the presented operands
   always_comb begin
      sc_res     = '0;
      sc_illegal = 1'b0;
      case (bus.ALUC)
         OP_AND:   sc_res = a & b;
         OP_OR:    sc_res = a | b;
         OP_ADD:   sc_res = sum;
         OP_SUB:   sc_res = diff;
         OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, slt};
         OP_SLL:   sc_res = a << shamt;
         OP_SRL:   sc_res = a >> shamt;
         OP_CMPEQ: sc_res = diff;
         OP_CMPNE: sc_res = diff;
         OP_MUL:   sc_res = '0;
         default:  sc_illegal = 1'b1;
      endcase
      // CMPNE inverts the sense so Zero reads as "condition true"
      sc_zero = (bus.ALUC == OP_CMPNE) ? (sc_res != '0) : (sc_res == '0);
   end

`ifdef SEQ_ALU_OVF_EN
   logic sc_ovf;
   logic ovf_q;

   // signed overflow: operands agree in sign (ADD) or differ (SUB/CMP) and the result sign flips
   always_comb begin
      sc_ovf = 1'b0;
      case (bus.ALUC)
         OP_ADD:
            sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         OP_SUB, OP_CMPEQ, OP_CMPNE:
            sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         default:
            sc_ovf = 1'b0;
      endcase
   end

   assign bus.ovf = ovf_q;
`endif

   // control FSM with all handshake and result outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         res_q     <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
`ifdef SEQ_ALU_OVF_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  ready_q <= 1'b0;
                  if (bus.ALUC == OP_MUL) begin
                     mcand  <= ACC_W'(a);
                     mplier <= b;
                     acc    <= '0;
                     cnt    <= CNT_W'(WIDTH);
                     state  <= MUL;
                  end else begin
                     res_q     <= sc_res;
                     zero_q    <= sc_zero;
                     illegal_q <= sc_illegal;
`ifdef SEQ_ALU_OVF_EN
                     ovf_q     <= sc_ovf;
`endif
                     valid_q   <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            MUL: begin
               acc    <= next_acc;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               // the final step lands directly in DONE so acceptance-to-valid is WIDTH+1 edges
               if (cnt == CNT_W'(1)) begin
                  res_q     <= next_acc[WIDTH-1:0];
                  zero_q    <= (next_acc[WIDTH-1:0] == '0);
                  illegal_q <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
                  ovf_q     <= |next_acc[ACC_W-1:WIDTH];
`endif
                  valid_q   <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.out_valid = valid_q;
   assign bus.ALU_OUT   = res_q;
   assign bus.Zero      = zero_q;
   assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu against a behavioural model (ovf checks under SEQ_ALU_OVF_EN)
module tb_seq_alu;
   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // absolute time bound
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // reference behaviour from the opcode table, using plain integer arithmetic
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic z, output logic ill,
                                 output logic ov, output int lat);
      longint sa, sb, s, smax, smin;
      logic [2*W-1:0] p;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (longint'(1) <<< (W-1)) - 1;
      smin = -(longint'(1) <<< (W-1));
      ill  = 1'b0;
      ov   = 1'b0;
      lat  = 1;
      r    = '0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin s = sa + sb; r = W'(s); ov = (s > smax) || (s < smin); end
         4'b0110, 4'b1000, 4'b1100: begin s = sa - sb; r = W'(s); ov = (s > smax) || (s < smin); end
         4'b0111: r = (sa < sb) ? W'(1) : W'(0);
         4'b0100: r = a << (b % W);
         4'b0101: r = a >> (b % W);
         4'b0011: begin
            p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            r   = p[W-1:0];
            ov  = (p >> W) != 0;
            lat = W + 1;
         end
         default: begin r = '0; ill = 1'b1; end
      endcase
      z = (op == 4'b1100) ? (r != '0) : (r == '0);
   endfunction

   // present one op, return edges from acceptance until out_valid is seen
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      int n;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      bus.ALUC     = op;
      bus.ALUIN1   = a;
      bus.ALUIN2   = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.ALUC     = 4'($urandom);
      bus.ALUIN1   = $urandom;
      bus.ALUIN2   = $urandom;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.ALU_OUT !== '0) begin failures++; $display("FAIL reset_alu_out got=%h exp=0", bus.ALU_OUT); end
      checks++; if (bus.Zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", bus.Zero); end
      checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
`ifdef SEQ_ALU_OVF_EN
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_add_sub_wrap();
      int lat;
      run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, lat);
      checks++; if (lat !== 1) begin failures++; $display("FAIL add_wrap_latency got=%0d exp=1", lat); end
      checks++; if (bus.ALU_OUT !== 32'h0) begin failures++; $display("FAIL add_wrap_result got=%h exp=0", bus.ALU_OUT); end
      checks++; if (bus.Zero !== 1'b1) begin failures++; $display("FAIL add_wrap_zero got=%b exp=1", bus.Zero); end
      consume();
      run_op(4'b0110, 32'd5, 32'd7, lat);
      checks++; if (bus.ALU_OUT !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_wrap_result got=%h exp=fffffffe", bus.ALU_OUT); end
      checks++; if (bus.Zero !== 1'b0) begin failures++; $display("FAIL sub_wrap_zero got=%b exp=0", bus.Zero); end
      consume();
   endtask

   task automatic test_compare();
      int lat;
      run_op(4'b1000, 32'h1234, 32'h1234, lat);
      checks++; if (bus.Zero !== 1'b1) begin failures++; $display("FAIL cmpeq_equal_zero got=%b exp=1", bus.Zero); end
      consume();
      run_op(4'b1100, 32'h1234, 32'h1234, lat);
      checks++; if (bus.Zero !== 1'b0) begin failures++; $display("FAIL cmpne_equal_zero got=%b exp=0", bus.Zero); end
      consume();
      run_op(4'b1100, 32'd3, 32'd4, lat);
      checks++; if (bus.Zero !== 1'b1) begin failures++; $display("FAIL cmpne_diff_zero got=%b exp=1", bus.Zero); end
      checks++; if (bus.ALU_OUT !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cmpne_diff_result got=%h exp=ffffffff", bus.ALU_OUT); end
      consume();
   endtask

   task automatic test_mul_backpressure();
      int lat;
      bus.out_ready = 1'b0;
      run_op(4'b0011, 32'h0001_0003, 32'h0000_0005, lat);
      checks++; if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
      checks++; if (bus.ALU_OUT !== 32'h0005_000F) begin failures++; $display("FAIL mul_result got=%h exp=0005000f", bus.ALU_OUT); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (bus.out_valid !== 1'b1 || bus.ALU_OUT !== 32'h0005_000F || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mul_hold cycle=%0d got valid=%b out=%h ready=%b exp valid=1 out=0005000f ready=0",
                     i, bus.out_valid, bus.ALU_OUT, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      #2;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mul_no_same_cycle_ready got=%b exp=0", bus.in_ready); end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL mul_release got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_slt_shift_illegal();
      int lat;
      run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, lat);
      checks++; if (bus.ALU_OUT !== 32'd1) begin failures++; $display("FAIL slt_result got=%h exp=1", bus.ALU_OUT); end
      consume();
      run_op(4'b0100, 32'd1, 32'd31, lat);
      checks++; if (bus.ALU_OUT !== 32'h8000_0000) begin failures++; $display("FAIL sll_result got=%h exp=80000000", bus.ALU_OUT); end
      consume();
      run_op(4'b0101, 32'h8000_0000, 32'd31, lat);
      checks++; if (bus.ALU_OUT !== 32'd1) begin failures++; $display("FAIL srl_result got=%h exp=1", bus.ALU_OUT); end
      checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL srl_illegal got=%b exp=0", bus.illegal); end
      consume();
      run_op(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, lat);
      checks++; if (lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
      checks++; if (bus.ALU_OUT !== 32'h0 || bus.Zero !== 1'b1 || bus.illegal !== 1'b1) begin
         failures++; $display("FAIL illegal_op got out=%h zero=%b ill=%b exp out=0 zero=1 ill=1", bus.ALU_OUT, bus.Zero, bus.illegal);
      end
      consume();
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      run_op(4'b0010, 32'd2, 32'd2, lat);
      consume();
      bus.ALUC     = 4'b0011;
      bus.ALUIN1   = 32'd7;
      bus.ALUIN2   = 32'd9;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.ALU_OUT !== '0) begin
         failures++; $display("FAIL midmul_reset got valid=%b out=%h exp valid=0 out=0", bus.out_valid, bus.ALU_OUT);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL midmul_release got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
      end
      // the discarded MUL must never surface a result
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) break;
      end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midmul_ghost_result got valid=%b exp=0", bus.out_valid); end
      run_op(4'b0010, 32'd2, 32'd3, lat);
      checks++; if (lat !== 1 || bus.ALU_OUT !== 32'd5) begin
         failures++; $display("FAIL midmul_next_add got lat=%0d out=%h exp lat=1 out=5", lat, bus.ALU_OUT);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      int lat, elat;
      logic [3:0] op;
      logic [W-1:0] a, b, r;
      logic z, ill, ov;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         op = (i == 3) ? 4'b0011 : 4'b0010;
         a  = $urandom;
         b  = $urandom_range(0, 255);
         model(op, a, b, r, z, ill, ov, elat);
         run_op(op, a, b, lat);
         checks++; if (lat !== elat || bus.ALU_OUT !== r) begin
            failures++; $display("FAIL b2b_result i=%0d got lat=%0d out=%h exp lat=%0d out=%h", i, lat, bus.ALU_OUT, elat, r);
         end
         @(posedge clk); #1;
         checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_consume i=%0d got valid=%b ready=%b exp valid=0 ready=1", i, bus.out_valid, bus.in_ready);
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_random();
      int lat, elat, d;
      logic [3:0] op;
      logic [W-1:0] a, b, r;
      logic z, ill, ov;
      logic [3:0] ops [11];
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0100, 4'b0101, 4'b1000, 4'b1100, 4'b0011, 4'b1011};
      for (int i = 0; i < 40; i++) begin
         op = (i % 7 == 6) ? 4'($urandom) : ops[$urandom_range(0, 10)];
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 2) == 0) b = b & 32'hFF;
         model(op, a, b, r, z, ill, ov, elat);
         run_op(op, a, b, lat);
         checks++; if (lat !== elat) begin failures++; $display("FAIL rand_latency i=%0d op=%b got=%0d exp=%0d", i, op, lat, elat); end
         d = $urandom_range(0, 3);
         for (int k = 0; k <= d; k++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.ALU_OUT !== r || bus.Zero !== z || bus.illegal !== ill) begin
               failures++;
               $display("FAIL rand_result i=%0d op=%b a=%h b=%h got out=%h z=%b ill=%b exp out=%h z=%b ill=%b",
                        i, op, a, b, bus.ALU_OUT, bus.Zero, bus.illegal, r, z, ill);
            end
`ifdef SEQ_ALU_OVF_EN
            checks++; if (bus.ovf !== ov) begin failures++; $display("FAIL rand_ovf i=%0d op=%b got=%b exp=%b", i, op, bus.ovf, ov); end
`endif
            if (k < d) begin @(posedge clk); #1; end
         end
         consume();
      end
   endtask

`ifdef SEQ_ALU_OVF_EN
   task automatic test_ovf();
      int lat;
      run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, lat);
      checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL ovf_add_max got=%b exp=1", bus.ovf); end
      consume();
      run_op(4'b0011, 32'h0001_0000, 32'h0001_0000, lat);
      checks++; if (bus.ALU_OUT !== 32'h0 || bus.ovf !== 1'b1) begin
         failures++; $display("FAIL ovf_mul got out=%h ovf=%b exp out=0 ovf=1", bus.ALU_OUT, bus.ovf);
      end
      consume();
      run_op(4'b0010, 32'd1, 32'd1, lat);
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ovf_add_small got=%b exp=0", bus.ovf); end
      consume();
   endtask
`endif

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.ALUC      = 4'b0000;
      bus.ALUIN1    = '0;
      bus.ALUIN2    = '0;
      test_reset();
      test_add_sub_wrap();
      test_compare();
      test_mul_backpressure();
      test_slt_shift_illegal();
      test_reset_mid_mul();
      test_back_to_back();
      test_random();
`ifdef SEQ_ALU_OVF_EN
      test_ovf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
